rc_add_sub_seq: RTL and testbench

Parametrised, multi-cycle ripple-carry adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock, LSB chunk first, and carries the inter-chunk carry in a register. It produces the same sum/difference and carry-out as the combinational 32-bit add/sub, and also signed-overflow and zero flags. It sits beside the ALU as the area-lean arithmetic unit, with a start/done handshake.

---
 rtl/rc_add_sub_seq.sv | 118 +++++++++++
 tb/tb_rc_add_sub_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/rc_add_sub_seq.sv
// Multi-cycle ripple-carry adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with a start/done handshake and registered Y/CO/V/ZERO results.
module rc_add_sub_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sna_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] y_o,
  output logic             co_o,
  output logic             v_o,
  output logic             zero_o
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NCHUNK - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             v_q, v_d;
  logic             zero_q, zero_d;

  int unsigned      base;
  logic [CHUNK:0]   chunk_sum;

  assign base      = 32'(cnt_q) * CHUNK;
  assign chunk_sum = {1'b0, op_a_q[base +: CHUNK]} + {1'b0, op_b_q[base +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    work_d  = work_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    co_d    = co_q;
    v_d     = v_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          op_a_d  = a_i;
          // Subtraction as A + ~B + 1: invert B here, seed the carry with 1.
          op_b_d  = b_i ^ {WIDTH{sna_i}};
          carry_d = sna_i;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        work_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = chunk_sum[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          y_d     = work_d;
          co_d    = chunk_sum[CHUNK];
          v_d     = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (work_d[WIDTH-1] != op_a_q[WIDTH-1]);
          zero_d  = (work_d == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      work_q  <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      work_q  <= work_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      v_q     <= v_d;
      zero_q  <= zero_d;
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);
  assign y_o    = y_q;
  assign co_o   = co_q;
  assign v_o    = v_q;
  assign zero_o = zero_q;

endmodule

// File: tb/tb_rc_add_sub_seq.sv
// Directed checks of rc_add_sub_seq (32/8) plus random sweeps over other WIDTH/CHUNK pairs.
module tb_rc_add_sub_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        sna;
  logic        busy, done, co, v, zero;
  logic [31:0] y;

  int total = 0;
  int bad   = 0;
  logic sweep_go = 1'b0;

  rc_add_sub_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(start),
    .a_i    (a),
    .b_i    (b),
    .sna_i  (sna),
    .busy_o (busy),
    .done_o (done),
    .y_o    (y),
    .co_o   (co),
    .v_o    (v),
    .zero_o (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] op_a, input logic [31:0] op_b, input logic s);
    @(negedge clk);
    a = op_a; b = op_b; sna = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called #1 after the accepting edge; counts edges until DONE, bounded.
  task automatic wait_done(output int lat, output int nbusy);
    lat = 0; nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic s, input logic [31:0] ey, input logic eco,
                         input logic ev, input logic ez);
    int lat, nbusy;
    start_op(op_a, op_b, s);
    wait_done(lat, nbusy);
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_y"}, 64'(y), 64'(ey));
    check({tag, "_co"}, 64'(co), 64'(eco));
    check({tag, "_v"}, 64'(v), 64'(ev));
    check({tag, "_zero"}, 64'(zero), 64'(ez));
  endtask

  initial begin
    int lat, nbusy, gap, ndone;
    start = 1'b0; a = '0; b = '0; sna = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_y", 64'(y), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_flags", 64'({co, v, zero}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First add, with busy-width and pulse-width checks.
    start_op(32'd5, 32'd3, 1'b0);
    wait_done(lat, nbusy);
    check("add_lat", 64'(lat), 64'd4);
    check("add_busy_cycles", 64'(nbusy), 64'd4);
    check("add_busy_at_done", 64'(busy), 64'd0);
    check("add_y", 64'(y), 64'h8);
    check("add_flags", 64'({co, v, zero}), 64'd0);
    @(posedge clk);
    #1 check("done_one_cycle", 64'(done), 64'd0);
    check("y_holds", 64'(y), 64'h8);

    run_vec("sub_borrow", 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_vec("sub_equal", 32'd5, 32'd5, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    run_vec("add_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_vec("add_wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    run_vec("sub_ovf", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_vec("add_xchunk", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b0);

    // START re-pulsed with new operands during RUN must be ignored.
    start_op(32'h10, 32'h20, 1'b0);
    @(negedge clk);
    a = 32'hFFFF_0000; b = 32'h1234; sna = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, nbusy);
    check("ignore_lat", 64'(lat), 64'd3);
    check("ignore_y", 64'(y), 64'h30);

    // Back-to-back with START held through DONE.
    @(negedge clk);
    a = 32'd1; b = 32'd2; sna = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 wait_done(lat, nbusy);
    check("b2b_lat", 64'(lat), 64'd4);
    @(posedge clk);
    #1 check("b2b_no_idle", 64'(busy), 64'd1);
    gap = 1;
    while (!done && gap < 40) begin
      @(posedge clk);
      #1 gap++;
    end
    start = 1'b0;
    check("b2b_period", 64'(gap), 64'd5);
    check("b2b_y", 64'(y), 64'h3);

    // Reset two cycles after accept aborts the op asynchronously.
    start_op(32'd7, 32'd9, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_y", 64'(y), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (8) begin
      @(posedge clk);
      #1 if (done) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    run_vec("after_rst", 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);

    sweep_go = 1'b1;
    wait (g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin && g_sweep[3].fin);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int unsigned W = (g == 2) ? 64 : 32;
    localparam int unsigned C = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 16 : 32;

    logic         st, sn, bz, dn, sco, sv, sz;
    logic [W-1:0] sa, sb, sy;
    logic         fin = 1'b0;

    rc_add_sub_seq #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .start_i(st),
      .a_i    (sa),
      .b_i    (sb),
      .sna_i  (sn),
      .busy_o (bz),
      .done_o (dn),
      .y_o    (sy),
      .co_o   (sco),
      .v_o    (sv),
      .zero_o (sz)
    );

    initial begin
      logic [W:0]   exp_sum;
      logic [W-1:0] bx;
      logic         ev;
      int           lat;
      st = 1'b0; sa = '0; sb = '0; sn = 1'b0;
      wait (sweep_go);
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        sa = W'({$urandom(), $urandom()});
        sb = W'({$urandom(), $urandom()});
        sn = 1'($urandom_range(0, 1));
        if (i == 0) begin
          sa = '1; sb = W'(1); sn = 1'b0;
        end
        bx      = sb ^ {W{sn}};
        exp_sum = {1'b0, sa} + {1'b0, bx} + (W + 1)'(sn);
        ev      = (sa[W-1] == bx[W-1]) && (exp_sum[W-1] != sa[W-1]);
        st = 1'b1;
        @(posedge clk);
        #1 st = 1'b0;
        lat = 0;
        while (!dn && lat < int'(W) + 8) begin
          @(posedge clk);
          #1 lat++;
        end
        check($sformatf("sweep%0d_lat", g), 64'(lat), 64'(W / C));
        check($sformatf("sweep%0d_y", g), 64'(sy), 64'(exp_sum[W-1:0]));
        check($sformatf("sweep%0d_co", g), 64'(sco), 64'(exp_sum[W]));
        check($sformatf("sweep%0d_v", g), 64'(sv), 64'(ev));
      end
      fin = 1'b1;
    end
  end

endmodule
